// File: rtl/cci_mpf_csrs_pkg.sv
// Shared constants and the shim event index map for the MPF CSR manager.
package cci_mpf_csrs_pkg;

  localparam int unsigned CCI_MPF_N_SHIM_EVENTS = 12;

  // Width of an MMIO read response word and the position of the sticky wrap flag in it
  localparam int unsigned CCI_MPF_RSP_WIDTH = 64;
  localparam int unsigned CCI_MPF_WRAP_BIT  = 63;

  // Bit position of each shim event in the packed event vector
  typedef enum logic [3:0] {
    VTP_4KB_HIT      = 4'd0,
    VTP_4KB_MISS     = 4'd1,
    VTP_2MB_HIT      = 4'd2,
    VTP_2MB_MISS     = 4'd3,
    VTP_PT_WALK_BUSY = 4'd4,
    VTP_FAILED_XLATE = 4'd5,
    VC_MAP_CHANGED   = 4'd6,
    WRO_RR           = 4'd7,
    WRO_RW           = 4'd8,
    WRO_WR           = 4'd9,
    WRO_WW           = 4'd10,
    PWRITE           = 4'd11
  } t_cci_mpf_shim_event_idx;

endpackage

// File: rtl/cci_mpf_prim_event_counter.sv
// Single event counter with a sticky wrap flag and a synchronous clear.
module cci_mpf_prim_event_counter #(
  parameter int unsigned CNT_WIDTH = 48
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 inc_i,
  input  logic                 clr_i,
  output logic [CNT_WIDTH-1:0] count_o,
  output logic                 wrap_o
);

  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 wrap_q, wrap_d;

  // Next-state: a clear wins over accumulation but keeps a coincident event
  always_comb begin
    count_d = count_q;
    wrap_d  = wrap_q;
    if (clr_i) begin
      count_d = CNT_WIDTH'(inc_i);
      wrap_d  = 1'b0;
    end else if (inc_i) begin
      count_d = count_q + CNT_WIDTH'(1);
      if (&count_q) begin
        wrap_d = 1'b1;
      end
    end
  end

  // Counter and wrap flag registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign count_o = count_q;
  assign wrap_o  = wrap_q;

endmodule

// File: rtl/cci_mpf_shim_csr_event_counters.sv
// Registers the shim event strobes, counts each one, and serves counter values to the
// CSR read path through a two-stage pipelined indexed read port.
module cci_mpf_shim_csr_event_counters
  import cci_mpf_csrs_pkg::*;
#(
  parameter int unsigned N_EVENTS  = CCI_MPF_N_SHIM_EVENTS,
  parameter int unsigned CNT_WIDTH = 48,
  parameter int unsigned IDX_WIDTH = (N_EVENTS > 1) ? $clog2(N_EVENTS) : 1
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [N_EVENTS-1:0]          events_i,
  input  logic                         rd_req_i,
  input  logic [IDX_WIDTH-1:0]         rd_idx_i,
  output logic                         rd_rsp_valid_o,
  output logic [CCI_MPF_RSP_WIDTH-1:0] rd_rsp_data_o,
  input  logic                         clr_req_i,
  input  logic [IDX_WIDTH-1:0]         clr_idx_i,
  input  logic                         clr_all_i
);

  logic [N_EVENTS-1:0]  ev_q;
  logic [N_EVENTS-1:0]  clr_vec;
  logic [CNT_WIDTH-1:0] cnt [N_EVENTS];
  logic [N_EVENTS-1:0]  wrap;

  logic                         rd_v1_q;
  logic [IDX_WIDTH-1:0]         rd_idx_q;
  logic                         rsp_valid_q;
  logic [CCI_MPF_RSP_WIDTH-1:0] rsp_data_q, rsp_data_d;

  // Event input stage: keeps the shim wires off any counter's combinational path
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ev_q <= '0;
    end else begin
      ev_q <= events_i;
    end
  end

  // Per-counter clear decode; out-of-range clr_idx matches no counter
  always_comb begin
    clr_vec = '0;
    for (int unsigned i = 0; i < N_EVENTS; i++) begin
      clr_vec[i] = clr_all_i | (clr_req_i & (clr_idx_i == IDX_WIDTH'(i)));
    end
  end

  for (genvar g = 0; g < N_EVENTS; g++) begin : gen_ctr
    cci_mpf_prim_event_counter #(
      .CNT_WIDTH(CNT_WIDTH)
    ) u_ctr (
      .clk    (clk),
      .reset_n(reset_n),
      .inc_i  (ev_q[g]),
      .clr_i  (clr_vec[g]),
      .count_o(cnt[g]),
      .wrap_o (wrap[g])
    );
  end

  // Read stage 1: capture the request and its index
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_v1_q  <= 1'b0;
      rd_idx_q <= '0;
    end else begin
      rd_v1_q  <= rd_req_i;
      rd_idx_q <= rd_idx_i;
    end
  end

  // Read stage 2 mux: selected counter formatted as {wrap, zeros, count}; unknown index reads 0
  always_comb begin
    rsp_data_d = '0;
    for (int unsigned i = 0; i < N_EVENTS; i++) begin
      if (rd_idx_q == IDX_WIDTH'(i)) begin
        rsp_data_d[CNT_WIDTH-1:0]      = cnt[i];
        rsp_data_d[CCI_MPF_WRAP_BIT]   = wrap[i];
      end
    end
  end

  // Read stage 2: response register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      rsp_valid_q <= rd_v1_q;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign rd_rsp_valid_o = rsp_valid_q;
  assign rd_rsp_data_o  = rsp_data_q;

endmodule

// File: tb/tb_cci_mpf_shim_csr_event_counters.sv
// Self-checking bench: two instances (48-bit and 4-bit counters) share one stimulus stream and
// are compared against a model that tracks total events since the last clear per counter.
module tb_cci_mpf_shim_csr_event_counters;

  localparam int unsigned NEV = 12;
  localparam int unsigned IW  = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [NEV-1:0] events;
  logic          rd_req;
  logic [IW-1:0] rd_idx;
  logic          clr_req;
  logic [IW-1:0] clr_idx;
  logic          clr_all;
  logic          v48, v4;
  logic [63:0]   d48, d4;

  always #5 clk = ~clk;

  cci_mpf_shim_csr_event_counters #(
    .N_EVENTS (NEV),
    .CNT_WIDTH(48),
    .IDX_WIDTH(IW)
  ) u_dut48 (
    .clk           (clk),
    .reset_n       (reset_n),
    .events_i      (events),
    .rd_req_i      (rd_req),
    .rd_idx_i      (rd_idx),
    .rd_rsp_valid_o(v48),
    .rd_rsp_data_o (d48),
    .clr_req_i     (clr_req),
    .clr_idx_i     (clr_idx),
    .clr_all_i     (clr_all)
  );

  cci_mpf_shim_csr_event_counters #(
    .N_EVENTS (NEV),
    .CNT_WIDTH(4),
    .IDX_WIDTH(IW)
  ) u_dut4 (
    .clk           (clk),
    .reset_n       (reset_n),
    .events_i      (events),
    .rd_req_i      (rd_req),
    .rd_idx_i      (rd_idx),
    .rd_rsp_valid_o(v4),
    .rd_rsp_data_o (d4),
    .clr_req_i     (clr_req),
    .clr_idx_i     (clr_idx),
    .clr_all_i     (clr_all)
  );

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  // Reference model: events seen since the last clear, and last cycle's event inputs
  longint unsigned total [NEV];
  logic [NEV-1:0]  ev_prev;

  typedef struct {int due; int idx; longint unsigned tot;} exp_t;
  typedef struct {int cyc; logic v48; logic v4; logic [63:0] d48; logic [63:0] d4;} obs_t;
  exp_t exp_q[$];
  obs_t obs_q[$];

  // Response word a counter of width w shows after tot events since clear
  function automatic logic [63:0] exp_word(longint unsigned tot, int w);
    logic [63:0] d;
    d     = tot & ((64'd1 << w) - 64'd1);
    d[63] = ((tot >> w) != 0);
    return d;
  endfunction

  // Record every response seen by either instance
  always @(negedge clk) begin
    if (v48 || v4) obs_q.push_back('{cyc, v48, v4, d48, d4});
  end

  // Advance one clock and update the model with the inputs that were held this cycle
  task automatic cycle();
    @(posedge clk);
    for (int i = 0; i < NEV; i++) begin
      if (clr_all || (clr_req && int'(clr_idx) == i)) total[i] = longint'(ev_prev[i]);
      else total[i] = total[i] + longint'(ev_prev[i]);
    end
    ev_prev = events;
    if (rd_req) begin
      if (int'(rd_idx) < NEV) exp_q.push_back('{cyc + 2, int'(rd_idx), total[rd_idx]});
      else exp_q.push_back('{cyc + 2, int'(rd_idx), 64'd0});
    end
    cyc++;
    #1;
  endtask

  task automatic idle_inputs();
    events = '0; rd_req = 1'b0; rd_idx = '0; clr_req = 1'b0; clr_idx = '0; clr_all = 1'b0;
  endtask

  task automatic clear_everything();
    clr_all = 1'b1;
    cycle();
    clr_all = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_n = 1'b0;
    for (int i = 0; i < NEV; i++) total[i] = 0;
    ev_prev = '0;
    #2;
    vectors++;
    if (v48 !== 1'b0 || v4 !== 1'b0 || d48 !== 64'd0 || d4 !== 64'd0) begin
      miscompares++;
      $display("FAIL reset_outputs got v=%b/%b d=%h/%h want 0", v48, v4, d48, d4);
    end
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    for (int k = 0; k < NEV; k++) begin
      rd_req = 1'b1; rd_idx = IW'(k);
      cycle();
    end
    idle_inputs();
    repeat (3) cycle();
    vectors++;
    if (obs_q.size() != NEV) begin
      miscompares++;
      $display("FAIL reset_read_count got %0d want %0d", obs_q.size(), NEV);
    end
    foreach (exp_q[k]) if (k < obs_q.size()) begin
      vectors++;
      if (obs_q[k].cyc != exp_q[k].due || !obs_q[k].v48 || !obs_q[k].v4 ||
          obs_q[k].d48 !== 64'd0 || obs_q[k].d4 !== 64'd0) begin
        miscompares++;
        $display("FAIL reset_read idx=%0d cyc got %0d want %0d data got %h/%h want 0",
                 exp_q[k].idx, obs_q[k].cyc, exp_q[k].due, obs_q[k].d48, obs_q[k].d4);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_counting();
    clear_everything();
    for (int k = 0; k < 100; k++) begin
      events = '0;
      events[4] = 1'b1;
      events[0] = (k < 10 && k % 2 == 0);
      cycle();
    end
    events = '0;
    rd_req = 1'b1; rd_idx = 4'd0; cycle();
    rd_idx = 4'd4; cycle();
    idle_inputs();
    repeat (3) cycle();
    vectors++;
    if (obs_q.size() != 2) begin
      miscompares++;
      $display("FAIL count_resp_count got %0d want 2", obs_q.size());
    end else begin
      vectors += 2;
      if (obs_q[0].d48 !== 64'd5 || obs_q[0].cyc != exp_q[0].due) begin
        miscompares++;
        $display("FAIL count_idx0 got %h @%0d want 5 @%0d", obs_q[0].d48, obs_q[0].cyc,
                 exp_q[0].due);
      end
      if (obs_q[1].d48 !== 64'd100 || obs_q[1].d4 !== exp_word(100, 4)) begin
        miscompares++;
        $display("FAIL count_idx4 got %h/%h want %h/%h", obs_q[1].d48, obs_q[1].d4,
                 64'd100, exp_word(100, 4));
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_wrap_and_clear();
    clear_everything();
    for (int k = 0; k < 34; k++) begin
      events = (k % 2 == 0) ? 12'h004 : 12'h000;
      cycle();
    end
    events = '0;
    rd_req = 1'b1; rd_idx = 4'd2; cycle();
    clr_req = 1'b1; clr_idx = 4'd2; cycle();
    idle_inputs();
    repeat (3) cycle();
    vectors++;
    if (obs_q.size() != 2) begin
      miscompares++;
      $display("FAIL wrap_resp_count got %0d want 2", obs_q.size());
    end else begin
      vectors += 3;
      if (obs_q[0].d4 !== 64'h8000_0000_0000_0001) begin
        miscompares++;
        $display("FAIL wrap_flag_4b got %h want 8000000000000001", obs_q[0].d4);
      end
      if (obs_q[0].d48 !== 64'd17) begin
        miscompares++;
        $display("FAIL wrap_48b got %h want 11", obs_q[0].d48);
      end
      if (obs_q[1].d4 !== 64'd0 || obs_q[1].d48 !== 64'd0) begin
        miscompares++;
        $display("FAIL clr_req_read got %h/%h want 0", obs_q[1].d48, obs_q[1].d4);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_clr_all_with_event();
    for (int k = 0; k < 10; k++) begin
      events = NEV'($urandom);
      cycle();
    end
    events = 12'h080;
    cycle();
    events = '0; clr_all = 1'b1; clr_req = 1'b1; clr_idx = 4'd3;
    cycle();
    idle_inputs();
    for (int k = 0; k < NEV; k++) begin
      rd_req = 1'b1; rd_idx = IW'(k);
      cycle();
    end
    idle_inputs();
    repeat (3) cycle();
    vectors++;
    if (obs_q.size() != NEV) begin
      miscompares++;
      $display("FAIL clr_all_resp_count got %0d want %0d", obs_q.size(), NEV);
    end
    foreach (exp_q[k]) if (k < obs_q.size()) begin
      logic [63:0] want;
      want = (exp_q[k].idx == 7) ? 64'd1 : 64'd0;
      vectors++;
      if (obs_q[k].d48 !== want || obs_q[k].d4 !== want || obs_q[k].cyc != exp_q[k].due) begin
        miscompares++;
        $display("FAIL clr_all idx=%0d got %h/%h @%0d want %h @%0d", exp_q[k].idx,
                 obs_q[k].d48, obs_q[k].d4, obs_q[k].cyc, want, exp_q[k].due);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 20; k++) begin
      events  = NEV'($urandom);
      rd_req  = 1'b1;
      rd_idx  = IW'(k % 14);
      clr_req = ($urandom_range(0, 3) == 0);
      clr_idx = IW'($urandom_range(0, 15));
      cycle();
    end
    idle_inputs();
    repeat (3) cycle();
    vectors++;
    if (obs_q.size() != 20) begin
      miscompares++;
      $display("FAIL b2b_resp_count got %0d want 20", obs_q.size());
    end
    foreach (exp_q[k]) if (k < obs_q.size()) begin
      vectors++;
      if (obs_q[k].cyc != exp_q[k].due || !obs_q[k].v48 || !obs_q[k].v4 ||
          obs_q[k].d48 !== exp_word(exp_q[k].tot, 48) ||
          obs_q[k].d4 !== exp_word(exp_q[k].tot, 4)) begin
        miscompares++;
        $display("FAIL b2b idx=%0d got %h/%h @%0d want %h/%h @%0d", exp_q[k].idx,
                 obs_q[k].d48, obs_q[k].d4, obs_q[k].cyc, exp_word(exp_q[k].tot, 48),
                 exp_word(exp_q[k].tot, 4), exp_q[k].due);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_reset_mid_read();
    for (int k = 0; k < 8; k++) begin
      events = 12'h010;
      cycle();
    end
    events = '0;
    rd_req = 1'b1; rd_idx = 4'd4; cycle();
    cycle();
    rd_req = 1'b0;
    #3;
    vectors++;
    if (v48 !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_read_valid got %b want 1", v48);
    end
    reset_n = 1'b0;
    #1;
    vectors++;
    if (v48 !== 1'b0 || v4 !== 1'b0 || d48 !== 64'd0) begin
      miscompares++;
      $display("FAIL async_reset_drop got v=%b/%b d=%h want 0", v48, v4, d48);
    end
    @(posedge clk);
    cyc++;
    #1 reset_n = 1'b1;
    for (int i = 0; i < NEV; i++) total[i] = 0;
    ev_prev = '0;
    exp_q.delete(); obs_q.delete();
    rd_req = 1'b1; rd_idx = 4'd4; cycle();
    idle_inputs();
    repeat (3) cycle();
    vectors++;
    if (obs_q.size() != 1) begin
      miscompares++;
      $display("FAIL post_reset_resp_count got %0d want 1", obs_q.size());
    end else begin
      vectors++;
      if (obs_q[0].d48 !== 64'd0 || obs_q[0].d4 !== 64'd0 || obs_q[0].cyc != exp_q[0].due) begin
        miscompares++;
        $display("FAIL post_reset_read got %h/%h @%0d want 0 @%0d", obs_q[0].d48, obs_q[0].d4,
                 obs_q[0].cyc, exp_q[0].due);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  initial begin
    test_reset();
    test_counting();
    test_wrap_and_clear();
    test_clr_all_with_event();
    test_back_to_back();
    test_reset_mid_read();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
